// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and FSM state type for alu_pipe.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_NEG = 6'd6;
  localparam logic [5:0] OP_AVG = 6'd7;
  localparam logic [5:0] OP_ABS = 6'd8;
  localparam logic [5:0] OP_NOT = 6'd9;
  localparam logic [5:0] OP_AND = 6'd10;
  localparam logic [5:0] OP_SUB = 6'd11;
  localparam logic [5:0] OP_OR  = 6'd12;
  localparam logic [5:0] OP_MAX = 6'd13;
  localparam logic [5:0] OP_MIN = 6'd14;
  localparam logic [5:0] OP_MUL = 6'd15;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_ILL  = 3;

  typedef enum logic {StIdle, StMul} state_e;

  function automatic logic [3:0] make_flags(input logic ill, input logic ovf,
                                            input logic neg, input logic zero);
    logic [3:0] f;
    f            = '0;
    f[FLAG_ILL]  = ill;
    f[FLAG_OVF]  = ovf;
    f[FLAG_NEG]  = neg;
    f[FLAG_ZERO] = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative signed multiplier: shift-add on operand magnitudes, one multiplier bit per cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               run,
  input  logic               ack,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // Unsigned magnitude of the most-negative value is still exact in WIDTH bits.
  assign mag_a    = a[WIDTH-1] ? -a : a;
  assign mag_b    = b[WIDTH-1] ? -b : b;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = run && (count_q == CntLast);
  assign product  = neg_q ? -acc_step : acc_step;

  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    if (start) begin
      count_d  = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
    end else if (run && !done) begin
      count_d  = count_q + 1'b1;
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (done && ack) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with a single output register; single-cycle ops plus an optional
// iterative multiply that blocks new requests while it runs.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam bit MulOn = (MUL_EN != 0);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic               out_free, accept, is_mul, load_alu, load_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     mul_upper;

  logic [WIDTH-1:0] comb_res, fin_res, sum, diff;
  logic             comb_ovf, comb_ill, fin_ovf, fin_ill;
  logic [WIDTH:0]   avg_sum, avg_adj;

  assign busy      = (state_q == StMul);
  assign out_valid = valid_q;
  assign result    = res_q;
  assign flags     = flags_q;
  assign out_free  = !valid_q || out_ready;
  assign in_ready  = !reset && !busy && out_free;
  assign accept    = in_valid && in_ready;
  assign is_mul    = MulOn && (opcode == OP_MUL);
  assign load_alu  = accept && !is_mul;
  assign load_mul  = busy && mul_done && out_free;

  assign sum     = a + b;
  assign diff    = a - b;
  assign avg_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  // Bias odd negative sums up by one so the shift truncates toward zero.
  assign avg_adj = avg_sum + {{WIDTH{1'b0}}, avg_sum[WIDTH] & avg_sum[0]};

  always_comb begin
    comb_res = '0;
    comb_ovf = 1'b0;
    comb_ill = 1'b0;
    case (opcode)
      OP_ADD: begin
        comb_res = sum;
        comb_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        comb_res = diff;
        comb_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: comb_res = a ^ b;
      OP_AND: comb_res = a & b;
      OP_OR:  comb_res = a | b;
      OP_NOT: comb_res = ~a;
      OP_NEG: begin
        comb_res = -a;
        comb_ovf = (a == MinVal);
      end
      OP_ABS: begin
        comb_res = a[WIDTH-1] ? -a : a;
        comb_ovf = (a == MinVal);
      end
      OP_AVG: comb_res = WIDTH'($signed(avg_adj) >>> 1);
      OP_MAX: comb_res = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN: comb_res = ($signed(a) < $signed(b)) ? a : b;
      OP_MUL: comb_ill = !MulOn;
      default: comb_ill = 1'b1;
    endcase
  end

  // Product fits in WIDTH bits only if its top WIDTH+1 bits are a pure sign extension.
  assign mul_upper = mul_prod[2*WIDTH-1:WIDTH-1];

  always_comb begin
    fin_res = '0;
    fin_ovf = 1'b0;
    fin_ill = 1'b0;
    if (load_mul) begin
      fin_res = mul_prod[WIDTH-1:0];
      fin_ovf = !((&mul_upper) || !(|mul_upper));
    end else if (comb_ill) begin
      fin_ill = 1'b1;
    end else begin
      fin_res = comb_res;
      fin_ovf = comb_ovf;
    end
  end

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (load_alu || load_mul) begin
      valid_d = 1'b1;
      res_d   = fin_res;
      flags_d = make_flags(fin_ill, fin_ovf, fin_res[WIDTH-1], fin_res == '0);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept && is_mul) state_d = StMul;
      StMul:  if (mul_done && out_free) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  if (MulOn) begin : g_mul
    alu_mul_seq #(
      .WIDTH (WIDTH)
    ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && is_mul),
      .run     (busy),
      .ack     (out_free),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32) against a 64-bit arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_pipe #(
    .WIDTH  (32),
    .MUL_EN (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: evaluate in 64-bit signed arithmetic, overflow if the value does not fit.
  function automatic void model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f);
    longint sx, sy, full, back;
    logic   ill, ovf, range_chk;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    full = 0;
    ill = 1'b0;
    range_chk = 1'b0;
    case (op)
      6'd4:  begin full = sx + sy; range_chk = 1'b1; end
      6'd5:  full = sx ^ sy;
      6'd6:  begin full = -sx; range_chk = 1'b1; end
      6'd7:  full = (sx + sy) / 2;
      6'd8:  begin full = (sx < 0) ? -sx : sx; range_chk = 1'b1; end
      6'd9:  full = ~sx;
      6'd10: full = sx & sy;
      6'd11: begin full = sx - sy; range_chk = 1'b1; end
      6'd12: full = sx | sy;
      6'd13: full = (sx > sy) ? sx : sy;
      6'd14: full = (sx < sy) ? sx : sy;
      6'd15: begin full = sx * sy; range_chk = 1'b1; end
      default: ill = 1'b1;
    endcase
    r = ill ? 32'd0 : full[31:0];
    back = longint'($signed(r));
    ovf = range_chk && (full != back);
    f = {ill, ovf, r[31], r == 32'd0};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'h0000_0000;
      3: return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction

  task automatic single(input string tag, input logic [5:0] op, input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] er;
    logic [3:0]  ef;
    model(op, x, y, er, ef);
    in_valid = 1'b1; opcode = op; a = x; b = y;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  task automatic mul(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [3:0]  ef;
    int lat, busy_cnt, rdy_bad;
    model(6'd15, x, y, er, ef);
    in_valid = 1'b1; opcode = 6'd15; a = x; b = y;
    step();
    in_valid = 1'b0;
    lat = 1; busy_cnt = 0; rdy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      if (busy && in_ready) rdy_bad++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
    chk({tag, "_ready_while_busy"}, 32'(rdy_bad), 32'd0);
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    logic [31:0] er, hold_r;
    logic [3:0]  ef, hold_f;
    int          seen;

    reset = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0; out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed corner cases with hand-derived expectations.
    single("add_ovf", 6'd4, 32'h7fff_ffff, 32'h1);
    chk("add_ovf_const_res", result, 32'h8000_0000);
    chk("add_ovf_const_flags", 32'(flags), 32'b0110);
    single("avg_max", 6'd7, 32'h7fff_ffff, 32'h7fff_ffff);
    chk("avg_max_const_res", result, 32'h7fff_ffff);
    chk("avg_max_const_flags", 32'(flags), 32'b0000);
    single("avg_m3", 6'd7, 32'hffff_fffd, 32'h0);
    chk("avg_m3_const_res", result, 32'hffff_ffff);
    single("abs_min", 6'd8, 32'h8000_0000, 32'h0);
    chk("abs_min_const_flags", 32'(flags), 32'b0110);
    single("neg_min", 6'd6, 32'h8000_0000, 32'h0);
    chk("neg_min_const_res", result, 32'h8000_0000);
    single("illegal20", 6'd20, 32'h1234_5678, 32'h9abc_def0);
    chk("illegal20_const_res", result, 32'd0);
    chk("illegal20_const_flags", 32'(flags), 32'b1001);
    step();
    chk("drained", 32'(out_valid), 32'd0);

    // Back-to-back random single-cycle ops, one result per cycle.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) op = 6'($urandom_range(4, 14));
      if (op == 6'd15) op = 6'd11;
      model(op, a, b, er, ef);
      opcode = op; a = pick(); b = pick(); in_valid = 1'b1;
      model(op, a, b, er, ef);
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("b2b_out_valid", 32'(out_valid), 32'd1);
      chk($sformatf("b2b_op%0d_result", op), result, er);
      chk($sformatf("b2b_op%0d_flags", op), 32'(flags), 32'(ef));
    end
    in_valid = 1'b0;
    step();

    // Multiply: directed then random.
    mul("mul_m7x6", 32'hffff_fff9, 32'd6);
    chk("mul_m7x6_const_res", result, 32'hffff_ffd6);
    step();
    mul("mul_ovf", 32'h0001_0000, 32'h0001_0000);
    chk("mul_ovf_const_flags", 32'(flags), 32'b0101);
    step();
    for (int i = 0; i < 8; i++) begin
      mul($sformatf("mul_rand%0d", i), pick(), pick());
      step();
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    single("bp_add", 6'd4, 32'd1, 32'd2);
    hold_r = result; hold_f = flags;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", result, 32'd3);
      chk("bp_hold_flags", 32'(flags), 32'(hold_f));
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    single("bp_release_xor", 6'd5, 32'hf0f0_f0f0, 32'h0ff0_0ff0);
    chk("bp_release_const_res", result, 32'hff00_ff00);
    step();

    // Reset in the middle of a multiply discards it.
    in_valid = 1'b1; opcode = 6'd15; a = 32'd5; b = 32'd7;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_mul_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    single("after_abort_sub", 6'd11, 32'h8000_0000, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
